// File: rtl/ldfp_align_if.sv
// ldfp_align_if: load-beat input, flush and converter-side output bundle for ldfp_align.
interface ldfp_align_if #(parameter int TAGW = 9);
    logic            in_vld;
    logic            in_rdy;
    logic [127:0]    in_data;
    logic [3:0]      in_off;
    logic            in_sz;
    logic [1:0]      in_dst;
    logic            in_cont;
    logic [TAGW-1:0] in_tag;
    logic            flush;
    logic            out_vld;
    logic            out_rdy;
    logic [64:0]     out_A;
    logic            out_to_sngl;
    logic            out_to_dbl;
    logic            out_to_ext;
    logic [TAGW-1:0] out_tag;
    logic            err;
    modport master (
        output in_vld, in_data, in_off, in_sz, in_dst, in_cont, in_tag, flush, out_rdy,
        input  in_rdy, out_vld, out_A, out_to_sngl, out_to_dbl, out_to_ext, out_tag, err
    );
    modport slave (
        input  in_vld, in_data, in_off, in_sz, in_dst, in_cont, in_tag, flush, out_rdy,
        output in_rdy, out_vld, out_A, out_to_sngl, out_to_dbl, out_to_ext, out_tag, err
    );
endinterface

// File: rtl/ldfp_align.sv
// ldfp_align: extracts a single/double FP operand from a 128-bit bank beat,
// merging the two halves of a line-crossing access into one output.
module ldfp_align #(parameter int TAGW = 9) (
    input logic clk,
    input logic rst,
    ldfp_align_if.slave bus
);
    typedef enum logic {IDLE, WAIT2} state_t;
    state_t          st;
    logic [63:0]     h_lo;
    logic [2:0]      h_len;
    logic            h_sz;
    logic [1:0]      h_dst;
    logic [TAGW-1:0] h_tag;
    logic            vld_q, err_q;
    logic [64:0]     a_q;
    logic [2:0]      sel_q;
    logic [TAGW-1:0] tag_q;
    logic            acc, split, illegal, join_b, fresh, direct, start, bad, load;
    logic [4:0]      end_b;
    logic [63:0]     sh, j, res;
    logic [1:0]      dst;
    assign bus.in_rdy = ~rst & ~bus.flush & (~vld_q | bus.out_rdy);
    assign acc     = bus.in_vld & bus.in_rdy;
    assign sh      = 64'(bus.in_data >> {bus.in_off, 3'b000});
    assign end_b   = {1'b0, bus.in_off} + (bus.in_sz ? 5'd8 : 5'd4);
    assign split   = end_b > 5'd16;
    assign illegal = (bus.in_dst == 2'b11) | (bus.in_sz & (bus.in_dst == 2'b00));
    assign join_b  = acc & bus.in_cont & (st == WAIT2);
    assign fresh   = acc & ~bus.in_cont;
    assign direct  = fresh & ~illegal & ~split;
    assign start   = fresh & ~illegal & split;
    assign bad     = acc & (bus.in_cont ? (st == IDLE) : ((st == WAIT2) | illegal));
    assign load    = direct | join_b;
    // Held low bytes sit at the bottom; second-beat bytes stack on top, excess drops off.
    assign j       = h_lo | (bus.in_data[63:0] << {h_len, 3'b000});
    assign res     = join_b ? (h_sz ? j : {32'b0, j[31:0]}) : (bus.in_sz ? sh : {32'b0, sh[31:0]});
    assign dst     = join_b ? h_dst : bus.in_dst;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= IDLE;
            vld_q <= 1'b0;
            err_q <= 1'b0;
            a_q   <= '0;
            sel_q <= '0;
            tag_q <= '0;
            h_lo  <= '0;
            h_len <= '0;
            h_sz  <= 1'b0;
            h_dst <= '0;
            h_tag <= '0;
        end else if (bus.flush) begin
            st    <= IDLE;
            vld_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= bad;
            if (load) begin
                vld_q <= 1'b1;
                a_q   <= {1'b0, res};
                sel_q <= {dst == 2'b10, dst == 2'b01, dst == 2'b00};
                tag_q <= join_b ? h_tag : bus.in_tag;
            end else if (bus.out_rdy) begin
                vld_q <= 1'b0;
            end
            if (start) begin
                st    <= WAIT2;
                h_lo  <= sh;
                h_len <= 3'd0 - bus.in_off[2:0];
                h_sz  <= bus.in_sz;
                h_dst <= bus.in_dst;
                h_tag <= bus.in_tag;
            end else if (acc) begin
                st <= IDLE;
            end
        end
    end
    assign bus.out_vld     = vld_q;
    assign bus.err         = err_q;
    assign bus.out_A       = a_q;
    assign bus.out_to_sngl = sel_q[0];
    assign bus.out_to_dbl  = sel_q[1];
    assign bus.out_to_ext  = sel_q[2];
    assign bus.out_tag     = tag_q;
endmodule

// File: tb/tb_ldfp_align.sv
// tb_ldfp_align: directed scenarios for ldfp_align with hand-computed results.
module tb_ldfp_align;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int nvec = 0;
    int nbad = 0;
    ldfp_align_if #(.TAGW(9)) bus ();
    ldfp_align #(.TAGW(9)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic beat(input logic [3:0] off, input logic sz, input logic [1:0] dst,
                        input logic cont, input logic [8:0] tag, input logic [127:0] data);
        bus.in_vld  = 1'b1;
        bus.in_off  = off;
        bus.in_sz   = sz;
        bus.in_dst  = dst;
        bus.in_cont = cont;
        bus.in_tag  = tag;
        bus.in_data = data;
    endtask

    task automatic idle();
        bus.in_vld  = 1'b0;
        bus.in_cont = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.in_data = '0; bus.in_off = '0; bus.in_sz = 0; bus.in_dst = 0; bus.in_tag = '0;
        bus.flush = 0; bus.out_rdy = 1;
        rst = 1;
        #1;
        nvec++; if (bus.out_vld !== 1'b0) begin nbad++; $display("FAIL rst_out_vld got %b want 0", bus.out_vld); end
        nvec++; if (bus.err !== 1'b0) begin nbad++; $display("FAIL rst_err got %b want 0", bus.err); end
        nvec++; if (bus.in_rdy !== 1'b0) begin nbad++; $display("FAIL rst_in_rdy got %b want 0", bus.in_rdy); end
        nvec++; if (bus.out_A !== 65'd0 || bus.out_tag !== 9'd0) begin nbad++; $display("FAIL rst_regs got A=%h tag=%h want 0", bus.out_A, bus.out_tag); end
        nvec++; if ({bus.out_to_ext, bus.out_to_dbl, bus.out_to_sngl} !== 3'b000) begin nbad++; $display("FAIL rst_sel got %b want 000", {bus.out_to_ext, bus.out_to_dbl, bus.out_to_sngl}); end
        @(negedge clk);
        rst = 0;
        step();
        nvec++; if (bus.in_rdy !== 1'b1) begin nbad++; $display("FAIL post_rst_in_rdy got %b want 1", bus.in_rdy); end
    endtask

    task automatic test_aligned();
        @(negedge clk);
        beat(4'd4, 0, 2'b00, 0, 9'd3, 128'h3F800000 << 32);
        step();
        nvec++; if (bus.out_vld !== 1'b1 || bus.out_A !== 65'h3F800000) begin nbad++; $display("FAIL aligned_sngl got vld=%b A=%h want 1 3f800000", bus.out_vld, bus.out_A); end
        nvec++; if ({bus.out_to_ext, bus.out_to_dbl, bus.out_to_sngl} !== 3'b001 || bus.out_tag !== 9'd3) begin nbad++; $display("FAIL aligned_sngl_sel got sel=%b tag=%0d want 001 3", {bus.out_to_ext, bus.out_to_dbl, bus.out_to_sngl}, bus.out_tag); end
        @(negedge clk);
        beat(4'd8, 1, 2'b01, 0, 9'd4, 128'h400921FB54442D18 << 64);
        step();
        nvec++; if (bus.out_A !== 65'h400921FB54442D18 || bus.out_to_dbl !== 1'b1) begin nbad++; $display("FAIL aligned_dbl got A=%h dbl=%b want 400921fb54442d18 1", bus.out_A, bus.out_to_dbl); end
        @(negedge clk);
        beat(4'd12, 0, 2'b10, 0, 9'd6, {32'hDEADBEEF, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF});
        step();
        nvec++; if (bus.out_vld !== 1'b1 || bus.out_A !== 65'hDEADBEEF || bus.out_to_ext !== 1'b1) begin nbad++; $display("FAIL edge16_sngl got vld=%b A=%h want 1 deadbeef", bus.out_vld, bus.out_A); end
        @(negedge clk);
        idle();
        step();
        nvec++; if (bus.out_vld !== 1'b0) begin nbad++; $display("FAIL drain got vld=%b want 0", bus.out_vld); end
    endtask

    task automatic test_split();
        @(negedge clk);
        beat(4'd12, 1, 2'b10, 0, 9'd5, 128'h00000000_BBBBBBBB_BBBBBBBB_BBBBBBBB);
        step();
        nvec++; if (bus.out_vld !== 1'b0 || bus.err !== 1'b0) begin nbad++; $display("FAIL split_first got vld=%b err=%b want 0 0", bus.out_vld, bus.err); end
        @(negedge clk);
        beat(4'd3, 0, 2'b00, 1, 9'd7, 128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_3FF00000);
        step();
        nvec++; if (bus.out_vld !== 1'b1 || bus.out_A !== 65'h3FF0000000000000) begin nbad++; $display("FAIL split_dbl got vld=%b A=%h want 1 3ff0000000000000", bus.out_vld, bus.out_A); end
        nvec++; if (bus.out_to_ext !== 1'b1 || bus.out_to_sngl !== 1'b0 || bus.out_tag !== 9'd5) begin nbad++; $display("FAIL split_dbl_meta got ext=%b tag=%0d want 1 5", bus.out_to_ext, bus.out_tag); end
        @(negedge clk);
        beat(4'd14, 0, 2'b00, 0, 9'd8, 128'h1234 << 112);
        step();
        @(negedge clk);
        beat(4'd0, 1, 2'b11, 1, 9'd1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF5678);
        step();
        nvec++; if (bus.out_A !== 65'h56781234 || bus.out_to_sngl !== 1'b1 || bus.out_tag !== 9'd8 || bus.err !== 1'b0) begin nbad++; $display("FAIL split_sngl got A=%h sngl=%b tag=%0d err=%b want 56781234 1 8 0", bus.out_A, bus.out_to_sngl, bus.out_tag, bus.err); end
        @(negedge clk);
        idle();
        step();
    endtask

    task automatic test_illegal();
        @(negedge clk);
        beat(4'd0, 0, 2'b11, 0, 9'd2, 128'h1);
        step();
        nvec++; if (bus.err !== 1'b1 || bus.out_vld !== 1'b0) begin nbad++; $display("FAIL illegal_dst got err=%b vld=%b want 1 0", bus.err, bus.out_vld); end
        @(negedge clk);
        beat(4'd0, 1, 2'b00, 0, 9'd2, 128'h1);
        step();
        nvec++; if (bus.err !== 1'b1 || bus.out_vld !== 1'b0) begin nbad++; $display("FAIL illegal_dbl2sngl got err=%b vld=%b want 1 0", bus.err, bus.out_vld); end
        @(negedge clk);
        idle();
        step();
        nvec++; if (bus.err !== 1'b0) begin nbad++; $display("FAIL illegal_pulse got err=%b want 0", bus.err); end
    endtask

    task automatic test_protocol();
        @(negedge clk);
        beat(4'd0, 0, 2'b00, 1, 9'd2, 128'h55);
        step();
        nvec++; if (bus.err !== 1'b1 || bus.out_vld !== 1'b0) begin nbad++; $display("FAIL cont_in_idle got err=%b vld=%b want 1 0", bus.err, bus.out_vld); end
        @(negedge clk);
        beat(4'd12, 1, 2'b10, 0, 9'd5, 128'h0);
        step();
        nvec++; if (bus.err !== 1'b0) begin nbad++; $display("FAIL err_single_cycle got err=%b want 0", bus.err); end
        @(negedge clk);
        beat(4'd0, 0, 2'b01, 0, 9'd9, 128'h11223344);
        step();
        nvec++; if (bus.err !== 1'b1 || bus.out_vld !== 1'b1 || bus.out_A !== 65'h11223344) begin nbad++; $display("FAIL nocont_in_wait2 got err=%b vld=%b A=%h want 1 1 11223344", bus.err, bus.out_vld, bus.out_A); end
        nvec++; if (bus.out_to_dbl !== 1'b1 || bus.out_tag !== 9'd9) begin nbad++; $display("FAIL nocont_meta got dbl=%b tag=%0d want 1 9", bus.out_to_dbl, bus.out_tag); end
        @(negedge clk);
        beat(4'd0, 0, 2'b00, 1, 9'd2, 128'h77);
        step();
        nvec++; if (bus.err !== 1'b1 || bus.out_vld !== 1'b0) begin nbad++; $display("FAIL held_discarded got err=%b vld=%b want 1 0", bus.err, bus.out_vld); end
        @(negedge clk);
        idle();
        step();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.out_rdy = 0;
        beat(4'd0, 0, 2'b00, 0, 9'd10, 128'hAAAA0001);
        step();
        nvec++; if (bus.out_vld !== 1'b1 || bus.out_A !== 65'hAAAA0001) begin nbad++; $display("FAIL bp_first got vld=%b A=%h want 1 aaaa0001", bus.out_vld, bus.out_A); end
        @(negedge clk);
        beat(4'd0, 0, 2'b01, 0, 9'd11, 128'hBBBB0002);
        for (int i = 0; i < 3; i++) begin
            step();
            nvec++; if (bus.out_vld !== 1'b1 || bus.out_A !== 65'hAAAA0001 || bus.out_tag !== 9'd10 || bus.in_rdy !== 1'b0) begin nbad++; $display("FAIL bp_hold%0d got vld=%b A=%h tag=%0d rdy=%b want 1 aaaa0001 10 0", i, bus.out_vld, bus.out_A, bus.out_tag, bus.in_rdy); end
        end
        @(negedge clk);
        bus.out_rdy = 1;
        #1;
        nvec++; if (bus.in_rdy !== 1'b1) begin nbad++; $display("FAIL bp_release_rdy got %b want 1", bus.in_rdy); end
        step();
        nvec++; if (bus.out_vld !== 1'b1 || bus.out_A !== 65'hBBBB0002 || bus.out_tag !== 9'd11 || bus.out_to_dbl !== 1'b1) begin nbad++; $display("FAIL bp_second got vld=%b A=%h tag=%0d want 1 bbbb0002 11", bus.out_vld, bus.out_A, bus.out_tag); end
        @(negedge clk);
        idle();
        step();
        nvec++; if (bus.out_vld !== 1'b0) begin nbad++; $display("FAIL bp_nodup got vld=%b want 0", bus.out_vld); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h01020304; vals[1] = 32'h05060708; vals[2] = 32'h090A0B0C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            beat(4'(i * 4), 0, 2'b00, 0, 9'(20 + i), 128'(vals[i]) << (i * 32));
            step();
            nvec++; if (bus.out_vld !== 1'b1 || bus.out_A !== {33'd0, vals[i]} || bus.out_tag !== 9'(20 + i)) begin nbad++; $display("FAIL b2b%0d got vld=%b A=%h tag=%0d want 1 %h %0d", i, bus.out_vld, bus.out_A, bus.out_tag, vals[i], 20 + i); end
        end
        @(negedge clk);
        idle();
        step();
    endtask

    task automatic test_flush();
        @(negedge clk);
        beat(4'd12, 1, 2'b10, 0, 9'd5, 128'h0);
        step();
        @(negedge clk);
        bus.flush = 1;
        beat(4'd0, 0, 2'b00, 1, 9'd1, 128'h3FF00000);
        #1;
        nvec++; if (bus.in_rdy !== 1'b0) begin nbad++; $display("FAIL flush_rdy got %b want 0", bus.in_rdy); end
        step();
        nvec++; if (bus.out_vld !== 1'b0 || bus.err !== 1'b0) begin nbad++; $display("FAIL flush_out got vld=%b err=%b want 0 0", bus.out_vld, bus.err); end
        @(negedge clk);
        bus.flush = 0;
        step();
        nvec++; if (bus.err !== 1'b1 || bus.out_vld !== 1'b0) begin nbad++; $display("FAIL flush_idle_cont got err=%b vld=%b want 1 0", bus.err, bus.out_vld); end
        @(negedge clk);
        idle();
        step();
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        beat(4'd12, 1, 2'b10, 0, 9'd5, 128'h0);
        step();
        @(negedge clk);
        idle();
        #2;
        rst = 1;
        #1;
        nvec++; if (bus.out_vld !== 1'b0 || bus.err !== 1'b0) begin nbad++; $display("FAIL rst_split got vld=%b err=%b want 0 0", bus.out_vld, bus.err); end
        @(negedge clk);
        rst = 0;
        bus.out_rdy = 0;
        beat(4'd0, 0, 2'b00, 0, 9'd12, 128'hCAFE0001);
        step();
        nvec++; if (bus.out_vld !== 1'b1 || bus.out_A !== 65'hCAFE0001 || bus.err !== 1'b0) begin nbad++; $display("FAIL rst_restart got vld=%b A=%h err=%b want 1 cafe0001 0", bus.out_vld, bus.out_A, bus.err); end
        @(negedge clk);
        idle();
        #2;
        rst = 1;
        #1;
        nvec++; if (bus.out_vld !== 1'b0 || bus.out_A !== 65'd0 || bus.err !== 1'b0) begin nbad++; $display("FAIL rst_stall got vld=%b A=%h err=%b want 0 0 0", bus.out_vld, bus.out_A, bus.err); end
        @(negedge clk);
        rst = 0;
        bus.out_rdy = 1;
        beat(4'd8, 1, 2'b01, 0, 9'd13, 128'h0123456789ABCDEF << 64);
        step();
        nvec++; if (bus.out_vld !== 1'b1 || bus.out_A !== 65'h0123456789ABCDEF || bus.err !== 1'b0) begin nbad++; $display("FAIL rst_clean got vld=%b A=%h err=%b want 1 0123456789abcdef 0", bus.out_vld, bus.out_A, bus.err); end
        @(negedge clk);
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_split();
        test_illegal();
        test_protocol();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
